// File: rtl/demux_sequencer.sv
// Serialises a 4-bit word onto a 1-to-4 demux (data/sel pair), holding each
// channel for HOLD_CYCLES tick-qualified cycles behind a valid/ready handshake.
`timescale 1ns/1ps

module demux_sequencer #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] word_in,
   input  logic       word_valid,
   output logic       word_ready,
   output logic       data,
   output logic [1:0] sel,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    word_q, word_d;
   logic [1:0]    sel_q, sel_d;
   logic          data_q, data_d;
   logic          word_ready_q, word_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      word_d       = word_q;
      sel_d        = sel_q;
      data_d       = data_q;
      word_ready_d = word_ready_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (word_valid && word_ready_q) begin
               state_d      = SEND;
               word_d       = word_in;
               sel_d        = 2'b00;
               data_d       = word_in[0];
               cnt_d        = '0;
               word_ready_d = 1'b0;
               busy_d       = 1'b1;
            end
         end
         SEND: begin
            if (tick) begin
               if (cnt_q != CNT_LAST) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else if (sel_q != 2'b11) begin
                  // sel and data move together so the demux never pairs a new channel with a stale bit
                  cnt_d  = '0;
                  sel_d  = sel_q + 2'd1;
                  data_d = word_q[sel_q + 2'd1];
               end else begin
                  state_d      = IDLE;
                  done_d       = 1'b1;
                  word_ready_d = 1'b1;
                  busy_d       = 1'b0;
                  data_d       = 1'b0;
                  sel_d        = 2'b00;
                  cnt_d        = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         word_q       <= '0;
         sel_q        <= 2'b00;
         data_q       <= 1'b0;
         word_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         word_q       <= word_d;
         sel_q        <= sel_d;
         data_q       <= data_d;
         word_ready_q <= word_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign word_ready = word_ready_q;
   assign data       = data_q;
   assign sel        = sel_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
